mcu2ipu_evt_collector: RTL and testbench



---
 rtl/mcu2ipu_evt_pkg.sv | 44 ++++
 rtl/evt_fifo.sv | 63 ++++++
 rtl/mcu2ipu_evt_collector.sv | 140 ++++++++++++++
 tb/tb_mcu2ipu_evt_collector.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu2ipu_evt_pkg.sv
// Shared definitions for the MCU2IPU event collector.
// Covers the record layout, the type codes and the pending-slot indices.
package mcu2ipu_evt_pkg;

  localparam int EVT_W     = 12;
  localparam int NUM_SLOTS = 5;

  localparam logic [3:0] TYPE_NMI   = 4'd1;
  localparam logic [3:0] TYPE_FAULT = 4'd2;
  localparam logic [3:0] TYPE_INT   = 4'd3;
  localparam logic [3:0] TYPE_RUN   = 4'd4;
  localparam logic [3:0] TYPE_ONL   = 4'd5;

  // Slot index order is also the priority order: lower index wins.
  localparam int SLOT_NMI   = 0;
  localparam int SLOT_FAULT = 1;
  localparam int SLOT_INT   = 2;
  localparam int SLOT_RUN   = 3;
  localparam int SLOT_ONL   = 4;

  typedef struct packed {
    logic [3:0] typ;
    logic [7:0] data;
  } evt_t;

  function automatic logic [3:0] slot_type(input logic [2:0] slot);
    case (slot)
      3'd0:    return TYPE_NMI;
      3'd1:    return TYPE_FAULT;
      3'd2:    return TYPE_INT;
      3'd3:    return TYPE_RUN;
      3'd4:    return TYPE_ONL;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [EVT_W-1:0] pack_evt(input logic [3:0] typ, input logic [7:0] data);
    evt_t e;
    e.typ  = typ;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous show-ahead FIFO with extra-MSB pointers.
// While empty, the read data holds the last head value that was presented.
module evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             push, pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = LVL_W'(wr_ptr_q - rd_ptr_q);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = rd_data;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mcu2ipu_evt_collector.sv
// MCU2IPU event front-end: edge/change detection, one pending slot per type,
// fixed-priority push into a show-ahead FIFO, and a saturating drop counter.
module mcu2ipu_evt_collector
  import mcu2ipu_evt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             MCU2IPU_CLK,
  input  logic             MCU2IPU_RESETn,
  input  logic [3:0]       MCU2IPU_CoreRunning,
  input  logic [3:0]       MCU2IPU_CoreOnline,
  input  logic             MCU2IPU_FaultInt,
  input  logic             MCU2IPU_NMI,
  input  logic             MCU2IPU_IntValid,
  input  logic [3:0]       MCU2IPU_IntInfo,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [EVT_W-1:0] EVT_DATA,
  output logic [LVL_W-1:0] EVT_LEVEL,
  output logic [7:0]       DROP_CNT,
  input  logic             DROP_CLR
);

  logic                 nmi_q, nmi_d, fault_q, fault_d, primed_q, primed_d;
  logic [3:0]           run_q, run_d, onl_q, onl_d;
  logic [NUM_SLOTS-1:0] pend_q, pend_d, det;
  logic [7:0]           pay_q   [NUM_SLOTS];
  logic [7:0]           pay_d   [NUM_SLOTS];
  logic [7:0]           det_pay [NUM_SLOTS];
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic [8:0]           drop_sum;
  logic [2:0]           n_drop, sel;
  logic                 sel_vld, push, fifo_full, fifo_empty;
  logic [EVT_W-1:0]     push_data;

  // RUN/ONL changes are suppressed until the first post-reset sample is captured.
  always_comb begin
    det = '0;
    for (int i = 0; i < NUM_SLOTS; i++) det_pay[i] = '0;
    det[SLOT_NMI]      = MCU2IPU_NMI & ~nmi_q;
    det[SLOT_FAULT]    = MCU2IPU_FaultInt & ~fault_q;
    det[SLOT_INT]      = MCU2IPU_IntValid;
    det_pay[SLOT_INT]  = {4'b0, MCU2IPU_IntInfo};
    det[SLOT_RUN]      = primed_q && (MCU2IPU_CoreRunning != run_q);
    det_pay[SLOT_RUN]  = {run_q, MCU2IPU_CoreRunning};
    det[SLOT_ONL]      = primed_q && (MCU2IPU_CoreOnline != onl_q);
    det_pay[SLOT_ONL]  = {onl_q, MCU2IPU_CoreOnline};
  end

  always_comb begin
    nmi_d    = MCU2IPU_NMI;
    fault_d  = MCU2IPU_FaultInt;
    run_d    = MCU2IPU_CoreRunning;
    onl_d    = MCU2IPU_CoreOnline;
    primed_d = 1'b1;
  end

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel     = 3'(i);
        sel_vld = 1'b1;
      end
    end
  end

  assign push      = sel_vld && !fifo_full;
  assign push_data = pack_evt(slot_type(sel), pay_q[sel]);

  // A slot freed by this cycle's push accepts a new detection without a drop.
  always_comb begin
    pend_d = pend_q;
    pay_d  = pay_q;
    n_drop = '0;
    if (push) pend_d[sel] = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (det[i]) begin
        if (pend_d[i]) begin
          n_drop = n_drop + 3'd1;
          if (i == SLOT_RUN || i == SLOT_ONL) pay_d[i][3:0] = det_pay[i][3:0];
        end else begin
          pend_d[i] = 1'b1;
          pay_d[i]  = det_pay[i];
        end
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q} + {6'b0, n_drop};
    if (DROP_CLR)         drop_cnt_d = '0;
    else if (drop_sum[8]) drop_cnt_d = 8'hFF;
    else                  drop_cnt_d = drop_sum[7:0];
  end

  always_ff @(posedge MCU2IPU_CLK or negedge MCU2IPU_RESETn) begin
    if (!MCU2IPU_RESETn) begin
      nmi_q      <= 1'b0;
      fault_q    <= 1'b0;
      run_q      <= '0;
      onl_q      <= '0;
      primed_q   <= 1'b0;
      pend_q     <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) pay_q[i] <= '0;
    end else begin
      nmi_q      <= nmi_d;
      fault_q    <= fault_d;
      run_q      <= run_d;
      onl_q      <= onl_d;
      primed_q   <= primed_d;
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
      pay_q      <= pay_d;
    end
  end

  evt_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EVT_W),
    .LVL_W(LVL_W)
  ) u_fifo (
    .clk     (MCU2IPU_CLK),
    .rst_n   (MCU2IPU_RESETn),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (EVT_READY),
    .rd_data (EVT_DATA),
    .level   (EVT_LEVEL),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign EVT_VALID = !fifo_empty;
  assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_mcu2ipu_evt_collector.sv
// Self-checking bench for mcu2ipu_evt_collector: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_mcu2ipu_evt_collector;

  localparam int DEPTH = 8;
  localparam int LVL_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       run, onl, info;
  logic             nmi, fault, intv, ready, clr;
  logic             valid;
  logic [11:0]      data;
  logic [LVL_W-1:0] level;
  logic [7:0]       drop;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [11:0] m_q[$];
  logic        m_pend [5];
  logic [7:0]  m_pay  [5];
  logic [3:0]  m_typ  [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  logic        m_nmi, m_fault, m_primed;
  logic [3:0]  m_run, m_onl;
  int          m_drop;
  logic [11:0] m_last;

  always #6 clk = ~clk;

  mcu2ipu_evt_collector #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .MCU2IPU_CLK         (clk),
    .MCU2IPU_RESETn      (rst_n),
    .MCU2IPU_CoreRunning (run),
    .MCU2IPU_CoreOnline  (onl),
    .MCU2IPU_FaultInt    (fault),
    .MCU2IPU_NMI         (nmi),
    .MCU2IPU_IntValid    (intv),
    .MCU2IPU_IntInfo     (info),
    .EVT_VALID           (valid),
    .EVT_READY           (ready),
    .EVT_DATA            (data),
    .EVT_LEVEL           (level),
    .DROP_CNT            (drop),
    .DROP_CLR            (clr)
  );

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 5; i++) begin
      m_pend[i] = 1'b0;
      m_pay[i]  = 8'h00;
    end
    m_nmi = 0; m_fault = 0; m_primed = 0; m_run = 0; m_onl = 0;
    m_drop = 0; m_last = 12'h000;
  endtask

  task automatic model_edge();
    logic       det [5];
    logic [7:0] dp  [5];
    int         sel, drops;
    logic       do_pop;
    do_pop = (m_q.size() > 0) && ready;
    sel = -1;
    if (m_q.size() < DEPTH) begin
      for (int i = 4; i >= 0; i--) if (m_pend[i]) sel = i;
    end
    det[0] = nmi && !m_nmi;                 dp[0] = 8'h00;
    det[1] = fault && !m_fault;             dp[1] = 8'h00;
    det[2] = intv;                          dp[2] = {4'h0, info};
    det[3] = m_primed && (run != m_run);    dp[3] = {m_run, run};
    det[4] = m_primed && (onl != m_onl);    dp[4] = {m_onl, onl};
    if (do_pop) void'(m_q.pop_front());
    if (sel >= 0) begin
      m_q.push_back({m_typ[sel], m_pay[sel]});
      m_pend[sel] = 1'b0;
    end
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      if (det[i]) begin
        if (m_pend[i]) begin
          drops++;
          if (i >= 3) m_pay[i][3:0] = dp[i][3:0];
        end else begin
          m_pend[i] = 1'b1;
          m_pay[i]  = dp[i];
        end
      end
    end
    if (clr) m_drop = 0;
    else     m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    m_nmi = nmi; m_fault = fault; m_run = run; m_onl = onl; m_primed = 1'b1;
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic [3:0] run0, input logic [3:0] onl0);
    rst_n = 1'b0;
    nmi = 0; fault = 0; intv = 0; info = 0; ready = 0; clr = 0;
    run = run0; onl = onl0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(4'h0, 4'h0);
    total++; if (valid !== 1'b0)    begin bad++; $display("FAIL reset_valid: got %h want 0", valid); end
    total++; if (data !== 12'h000)  begin bad++; $display("FAIL reset_data: got %h want 000", data); end
    total++; if (level !== 4'd0)    begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (drop !== 8'd0)     begin bad++; $display("FAIL reset_drop: got %0d want 0", drop); end
  endtask

  task automatic test_int_single();
    do_reset(4'h0, 4'h0);
    ready = 1; intv = 1; info = 4'hA;
    step();
    intv = 0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL int_early: got %h want 0", valid); end
    step();
    total++; if (valid !== 1'b1)   begin bad++; $display("FAIL int_valid: got %h want 1", valid); end
    total++; if (data !== 12'h30A) begin bad++; $display("FAIL int_data: got %h want 30a", data); end
    step();
    total++; if (valid !== 1'b0)   begin bad++; $display("FAIL int_one_cycle: got %h want 0", valid); end
    total++; if (data !== 12'h30A) begin bad++; $display("FAIL int_hold: got %h want 30a", data); end
  endtask

  task automatic test_priority();
    do_reset(4'h0, 4'h0);
    ready = 1; nmi = 1; fault = 1; intv = 1; info = 4'h3;
    step();
    intv = 0;
    step();
    total++; if (valid !== 1'b1 || data !== 12'h100) begin bad++; $display("FAIL prio_nmi: got %h/%h want 1/100", valid, data); end
    step();
    total++; if (valid !== 1'b1 || data !== 12'h200) begin bad++; $display("FAIL prio_fault: got %h/%h want 1/200", valid, data); end
    step();
    total++; if (valid !== 1'b1 || data !== 12'h303) begin bad++; $display("FAIL prio_int: got %h/%h want 1/303", valid, data); end
    nmi = 0; fault = 0;
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL prio_end: got %h want 0", valid); end
  endtask

  task automatic test_fill_full();
    logic [11:0] exp;
    do_reset(4'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      intv = 1; info = 4'(i); step();
      intv = 0; step();
    end
    total++; if (level !== 4'd8) begin bad++; $display("FAIL full_level: got %0d want 8", level); end
    intv = 1; info = 4'h8; step(); intv = 0; step();
    total++; if (level !== 4'd8 || drop !== 8'd0) begin bad++; $display("FAIL full_hold: got %0d/%0d want 8/0", level, drop); end
    intv = 1; info = 4'h9; step(); intv = 0; step();
    total++; if (drop !== 8'd1) begin bad++; $display("FAIL full_drop: got %0d want 1", drop); end
    ready = 1;
    for (int i = 0; i < 9; i++) begin
      exp = 12'h300 | 12'(i);
      total++; if (valid !== 1'b1 || data !== exp) begin bad++; $display("FAIL full_drain%0d: got %h/%h want 1/%h", i, valid, data, exp); end
      step();
    end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL full_empty: got %h want 0", valid); end
  endtask

  task automatic test_coalesce();
    logic [11:0] got[$];
    do_reset(4'h0, 4'h0);
    intv = 1;
    for (int i = 0; i < 8; i++) begin info = 4'(i); step(); end
    intv = 0;
    step();
    total++; if (level !== 4'd8 || drop !== 8'd0) begin bad++; $display("FAIL coal_fill: got %0d/%0d want 8/0", level, drop); end
    run = 4'h1; step();
    run = 4'h3; step();
    step();
    total++; if (drop !== 8'd1) begin bad++; $display("FAIL coal_drop: got %0d want 1", drop); end
    ready = 1;
    for (int c = 0; c < 20; c++) begin
      if (valid === 1'b1) got.push_back(data);
      step();
    end
    total++; if (got.size() != 9) begin bad++; $display("FAIL coal_count: got %0d want 9", got.size()); end
    if (got.size() == 9) begin
      total++; if (got[8] !== 12'h403) begin bad++; $display("FAIL coal_rec: got %h want 403", got[8]); end
      total++; if (got[7] !== 12'h307) begin bad++; $display("FAIL coal_order: got %h want 307", got[7]); end
    end
  endtask

  task automatic test_onl_prime();
    int seen;
    do_reset(4'h0, 4'hF);
    ready = 1; seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL onl_prime: got %0d records want 0", seen); end
    onl = 4'h7;
    step();
    step();
    total++; if (valid !== 1'b1 || data !== 12'h5F7) begin bad++; $display("FAIL onl_change: got %h/%h want 1/5f7", valid, data); end
  endtask

  task automatic test_drop_sat();
    do_reset(4'h0, 4'h0);
    intv = 1;
    repeat (320) step();
    total++; if (drop !== 8'd255) begin bad++; $display("FAIL drop_sat: got %0d want 255", drop); end
    clr = 1; step();
    total++; if (drop !== 8'd0) begin bad++; $display("FAIL drop_clr: got %0d want 0", drop); end
    clr = 0; step();
    total++; if (drop !== 8'd1) begin bad++; $display("FAIL drop_after_clr: got %0d want 1", drop); end
    intv = 0;
  endtask

  task automatic test_async_reset();
    do_reset(4'h0, 4'h0);
    intv = 1;
    repeat (4) step();
    intv = 0;
    step();
    total++; if (level !== 4'd4 || valid !== 1'b1) begin bad++; $display("FAIL arst_pre: got %0d/%h want 4/1", level, valid); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (level !== 4'd0 || valid !== 1'b0) begin bad++; $display("FAIL arst_now: got %0d/%h want 0/0", level, valid); end
    total++; if (data !== 12'h000) begin bad++; $display("FAIL arst_data: got %h want 000", data); end
  endtask

  task automatic test_random();
    do_reset(4'($urandom), 4'($urandom));
    for (int c = 0; c < 3000; c++) begin
      if ((c % 80) < 40) ready = ($urandom_range(0, 3) == 0);
      else               ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) nmi = ~nmi;
      if ($urandom_range(0, 7) == 0) fault = ~fault;
      intv = ($urandom_range(0, 2) == 0);
      info = 4'($urandom);
      if ($urandom_range(0, 5) == 0) run = 4'($urandom);
      if ($urandom_range(0, 5) == 0) onl = 4'($urandom);
      clr = ($urandom_range(0, 49) == 0);
      step();
      total++; if (valid !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_valid c%0d: got %h want %0d", c, valid, m_q.size() > 0); end
      total++; if (level !== LVL_W'(m_q.size())) begin bad++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, level, m_q.size()); end
      total++; if (drop !== 8'(m_drop)) begin bad++; $display("FAIL rnd_drop c%0d: got %0d want %0d", c, drop, m_drop); end
      if (m_q.size() > 0) begin
        total++; if (data !== m_last) begin bad++; $display("FAIL rnd_data c%0d: got %h want %h", c, data, m_last); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_int_single();
    test_priority();
    test_fill_full();
    test_coalesce();
    test_onl_prime();
    test_drop_sat();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
